// File: rtl/uart_cpu_port_pkg.sv
// Shared UART definitions: TX/RX state encodings, frame constants and the TX pin decode helper.
package lib_uart;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } TX_STATE;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } RX_STATE;

    // Line level driven for a given TX state; data_bit is the current shift-register LSB.
    function automatic logic tx_pin_level(input TX_STATE st, input logic data_bit);
        logic lvl;
        case (st)
            TX_START: lvl = 1'b0;
            TX_DATA:  lvl = data_bit;
            default:  lvl = IDLE_LEVEL;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_cpu_port_rx_core.sv
// 8N1 receiver: optional input synchroniser (UART_RX_SYNC_EN), falling-edge start detect,
// mid-bit sampling FSM and shift register. Emits a one-cycle rx_valid with rx_byte per good frame.
module uart_rx_core
    import lib_uart::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

    logic             line_s;
    logic             prev_r;
    logic             fall_s;
    RX_STATE          state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [2:0]       idx_r, idx_nxt_s;
    logic [7:0]       shift_r, shift_nxt_s;
    logic             valid_nxt_s;
    logic             rx_valid_r;
    logic [7:0]       rx_byte_r;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_r;

    // Two-flop synchroniser for the asynchronous RX pin, reset to the idle level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {2{IDLE_LEVEL}};
        end else begin
            sync_r <= {sync_r[0], uart_rx};
        end
    end

    assign line_s = sync_r[1];
`else
    assign line_s = uart_rx;
`endif

    assign fall_s = prev_r & ~line_s;

    // Edge-detect history, FSM state, counters and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_r     <= IDLE_LEVEL;
            state_r    <= RX_IDLE;
            cnt_r      <= CNT_ZERO;
            idx_r      <= 3'd0;
            shift_r    <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_byte_r  <= 8'h00;
        end else begin
            prev_r     <= line_s;
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            idx_r      <= idx_nxt_s;
            shift_r    <= shift_nxt_s;
            rx_valid_r <= valid_nxt_s;
            if (valid_nxt_s) begin
                rx_byte_r <= shift_r;
            end
        end
    end

    // Next-state logic; samples are taken when the down-counter reaches zero.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        shift_nxt_s = shift_r;
        valid_nxt_s = 1'b0;
        case (state_r)
            RX_IDLE: begin
                if (fall_s) begin
                    state_nxt_s = RX_START;
                    cnt_nxt_s   = HALF_LOAD;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            RX_START: begin
                if (cnt_r == CNT_ZERO) begin
                    // A line that is high again at mid start-bit was only a glitch.
                    if (line_s) begin
                        state_nxt_s = RX_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = RX_DATA;
                        cnt_nxt_s   = BIT_LOAD;
                        idx_nxt_s   = 3'd0;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_r == CNT_ZERO) begin
                    shift_nxt_s = {line_s, shift_r[7:1]};
                    cnt_nxt_s   = BIT_LOAD;
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = RX_STOP;
                        idx_nxt_s   = 3'd0;
                    end else begin
                        idx_nxt_s   = idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = RX_IDLE;
                    valid_nxt_s = line_s;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = RX_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                idx_nxt_s   = 3'd0;
            end
        endcase
    end

    assign rx_valid = rx_valid_r;
    assign rx_byte  = rx_byte_r;

endmodule

// File: rtl/uart_cpu_port.sv
// CPU-side UART port: 8N1 transmitter FSM plus rx_data/irr registers fed by uart_rx_core.
// Optional macro UART_RX_SYNC_EN adds a two-flop synchroniser on uart_rx.
module uart_cpu_port
    import lib_uart::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       irr,
    input  logic       ack
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    TX_STATE          tx_state_r, tx_state_nxt_s;
    logic [CNT_W-1:0] tx_cnt_r, tx_cnt_nxt_s;
    logic [2:0]       tx_idx_r, tx_idx_nxt_s;
    logic [7:0]       tx_shift_r, tx_shift_nxt_s;
    logic             uart_tx_r;
    logic             tx_busy_r;
    logic             rx_valid_s;
    logic [7:0]       rx_byte_s;
    logic [7:0]       rx_data_r;
    logic             irr_r;

    // TX state, counters and registered pin/busy outputs (decoded from next state).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_idx_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            uart_tx_r  <= IDLE_LEVEL;
            tx_busy_r  <= 1'b0;
        end else begin
            tx_state_r <= tx_state_nxt_s;
            tx_cnt_r   <= tx_cnt_nxt_s;
            tx_idx_r   <= tx_idx_nxt_s;
            tx_shift_r <= tx_shift_nxt_s;
            uart_tx_r  <= tx_pin_level(tx_state_nxt_s, tx_shift_nxt_s[0]);
            tx_busy_r  <= (tx_state_nxt_s != TX_IDLE);
        end
    end

    // TX next-state logic; requests outside IDLE are dropped, not queued.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        tx_cnt_nxt_s   = tx_cnt_r;
        tx_idx_nxt_s   = tx_idx_r;
        tx_shift_nxt_s = tx_shift_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_req) begin
                    tx_state_nxt_s = TX_START;
                    tx_cnt_nxt_s   = BIT_LOAD;
                    tx_idx_nxt_s   = 3'd0;
                    tx_shift_nxt_s = tx_data;
                end else begin
                    tx_cnt_nxt_s   = CNT_ZERO;
                end
            end
            TX_START: begin
                if (tx_cnt_r == CNT_ZERO) begin
                    tx_state_nxt_s = TX_DATA;
                    tx_cnt_nxt_s   = BIT_LOAD;
                end else begin
                    tx_cnt_nxt_s = tx_cnt_r - CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == CNT_ZERO) begin
                    tx_cnt_nxt_s = BIT_LOAD;
                    if (tx_idx_r == LAST_IDX) begin
                        tx_state_nxt_s = TX_STOP;
                        tx_idx_nxt_s   = 3'd0;
                    end else begin
                        tx_idx_nxt_s   = tx_idx_r + 3'd1;
                        tx_shift_nxt_s = {1'b0, tx_shift_r[7:1]};
                    end
                end else begin
                    tx_cnt_nxt_s = tx_cnt_r - CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == CNT_ZERO) begin
                    tx_state_nxt_s = TX_IDLE;
                end else begin
                    tx_cnt_nxt_s = tx_cnt_r - CNT_ONE;
                end
            end
            default: begin
                tx_state_nxt_s = TX_IDLE;
                tx_cnt_nxt_s   = CNT_ZERO;
                tx_idx_nxt_s   = 3'd0;
            end
        endcase
    end

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .rx_valid (rx_valid_s),
        .rx_byte  (rx_byte_s)
    );

    // Received-byte holding register and interrupt request; a new frame beats a same-cycle ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data_r <= 8'h00;
            irr_r     <= 1'b0;
        end else if (rx_valid_s) begin
            rx_data_r <= rx_byte_s;
            irr_r     <= 1'b1;
        end else if (ack) begin
            irr_r     <= 1'b0;
        end
    end

    assign tx_busy = tx_busy_r;
    assign uart_tx = uart_tx_r;
    assign rx_data = rx_data_r;
    assign irr     = irr_r;

endmodule

// File: tb/tb_uart_cpu_port.sv
// Directed, table-driven bench for uart_cpu_port at CLKS_PER_BIT=4.
module tb_uart_cpu_port;

    localparam int CPB = 4;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       tx_req  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       uart_rx = 1'b1;
    logic       ack     = 1'b0;
    logic       tx_busy;
    logic       uart_tx;
    logic [7:0] rx_data;
    logic       irr;

    uart_cpu_port #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx),
        .rx_data (rx_data),
        .irr     (irr),
        .ack     (ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 = start bit, bit 9 = stop bit
        int         inj_at;  // cycle into frame to issue an extra request, -1 for none
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pre_ack;
        int         ack_at;
        logic [7:0] exp_data;
        logic       exp_irr;
    } rx_vec_t;

    tx_vec_t tx_tab[3];
    rx_vec_t rx_tab[4];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tx(input logic [7:0] d, input logic [9:0] frame, input int inj_at);
        tx_data = d;
        tx_req  = 1'b1;
        step();
        tx_req  = 1'b0;
        for (int i = 0; i < 10 * CPB; i++) begin
            check1("tx_pin", uart_tx, frame[i / CPB]);
            check1("tx_busy_frame", tx_busy, 1'b1);
            if (i == inj_at) begin
                tx_req  = 1'b1;
                tx_data = 8'h3C;
            end else begin
                tx_req  = 1'b0;
            end
            step();
        end
        tx_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check1("tx_idle_busy", tx_busy, 1'b0);
            check1("tx_idle_pin", uart_tx, 1'b1);
            step();
        end
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop, input int ack_at);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        for (int t = 0; t < 10 * CPB + 4; t++) begin
            uart_rx = (t < 10 * CPB) ? frame[t / CPB] : 1'b1;
            ack     = (t == ack_at);
            step();
        end
        ack     = 1'b0;
        uart_rx = 1'b1;
    endtask

    initial begin
        tx_tab[0] = '{data: 8'hA5, frame: 10'b1101001010, inj_at: -1};
        tx_tab[1] = '{data: 8'hA5, frame: 10'b1101001010, inj_at: 10};
        tx_tab[2] = '{data: 8'h3C, frame: 10'b1001111000, inj_at: -1};

        rx_tab[0] = '{data: 8'h5A, stop: 1'b1, pre_ack: 1'b0, ack_at: -1,
                      exp_data: 8'h5A, exp_irr: 1'b1};
        rx_tab[1] = '{data: 8'h77, stop: 1'b0, pre_ack: 1'b1, ack_at: -1,
                      exp_data: 8'h5A, exp_irr: 1'b0};
        rx_tab[2] = '{data: 8'h11, stop: 1'b1, pre_ack: 1'b0, ack_at: 10 * CPB - 1 + SYNC_LAT,
                      exp_data: 8'h11, exp_irr: 1'b1};
        rx_tab[3] = '{data: 8'h22, stop: 1'b1, pre_ack: 1'b0, ack_at: -1,
                      exp_data: 8'h22, exp_irr: 1'b1};

        for (int i = 0; i < 3; i++) step();
        check1("rst_uart_tx", uart_tx, 1'b1);
        check1("rst_tx_busy", tx_busy, 1'b0);
        check8("rst_rx_data", rx_data, 8'h00);
        check1("rst_irr", irr, 1'b0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 3; v++) begin
            send_tx(tx_tab[v].data, tx_tab[v].frame, tx_tab[v].inj_at);
        end

        // One-cycle low glitch must be rejected as a false start.
        uart_rx = 1'b0;
        step();
        uart_rx = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) step();
        check1("glitch_irr", irr, 1'b0);
        check8("glitch_rx_data", rx_data, 8'h00);

        for (int v = 0; v < 4; v++) begin
            if (rx_tab[v].pre_ack) begin
                check1("irr_before_ack", irr, 1'b1);
                ack = 1'b1;
                step();
                ack = 1'b0;
                check1("ack_clears_irr", irr, 1'b0);
            end
            drive_rx(rx_tab[v].data, rx_tab[v].stop, rx_tab[v].ack_at);
            check8("rx_data", rx_data, rx_tab[v].exp_data);
            check1("rx_irr", irr, rx_tab[v].exp_irr);
        end

        // Reset in the middle of a transmission.
        tx_data = 8'h00;
        tx_req  = 1'b1;
        step();
        tx_req  = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check1("midtx_busy_pre", tx_busy, 1'b1);
        rst_n = 1'b0;
        step();
        check1("midtx_rst_pin", uart_tx, 1'b1);
        check1("midtx_rst_busy", tx_busy, 1'b0);
        check1("midtx_rst_irr", irr, 1'b0);
        check8("midtx_rst_rx_data", rx_data, 8'h00);
        rst_n = 1'b1;
        step();
        step();
        send_tx(8'h01, 10'b1000000010, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
